// File: rtl/seq_divider.sv
// Restoring shift-and-subtract divider, one quotient bit per clock, start/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN to add the is_signed port and signed (RISC-V M) semantics.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_RUN  | iterating, one quotient bit per clock
  // S_DONE | results valid, done pulse; start here is accepted

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] rem_r, dvd_r, dsr_r;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r;

  logic             accept, dsr_zero, last;
  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shifted, trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_nxt, dvd_nxt, q_fin, r_fin;

  assign accept   = start && (state != S_RUN);
  assign dsr_zero = (divisor == '0);
  assign last     = (cnt == CW'(1));

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign sgn_a = is_signed & dividend[WIDTH-1];
  assign sgn_b = is_signed & divisor[WIDTH-1];
`else
  assign sgn_a = 1'b0;
  assign sgn_b = 1'b0;
`endif

  // Most-negative / -1 falls out naturally: magnitude quotient is 2^(WIDTH-1), signs agree.
  assign mag_a = sgn_a ? (~dividend + 1'b1) : dividend;
  assign mag_b = sgn_b ? (~divisor + 1'b1) : divisor;

  // rem < divisor always, so the trial fits in WIDTH+1 bits and its MSB is the sign.
  assign shifted = {rem_r, dvd_r[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr_r};
  assign qbit    = ~trial[WIDTH];
  assign rem_nxt = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign dvd_nxt = {dvd_r[WIDTH-2:0], qbit};
  assign q_fin   = neg_q ? (~dvd_nxt + 1'b1) : dvd_nxt;
  assign r_fin   = neg_r ? (~rem_nxt + 1'b1) : rem_nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_nxt = dsr_zero ? S_DONE : S_RUN;
        else        state_nxt = S_IDLE;
      end
      S_RUN:   if (last) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_r       <= '0;
      dvd_r       <= '0;
      dsr_r       <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (dsr_zero) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        quotient    <= '0;
        remainder   <= '0;
        div_by_zero <= 1'b0;
        rem_r       <= '0;
        dvd_r       <= mag_a;
        dsr_r       <= mag_b;
        cnt         <= CW'(WIDTH);
        neg_q       <= sgn_a ^ sgn_b;
        neg_r       <= sgn_a;
      end
    end else if (state == S_RUN) begin
      rem_r <= rem_nxt;
      dvd_r <= dvd_nxt;
      cnt   <= cnt - 1'b1;
      if (last) begin
        quotient  <= q_fin;
        remainder <= r_fin;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider at WIDTH=8: directed cases plus random operands against an arithmetic model.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] dividend, divisor;
  logic         sgn_sel;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .is_signed(sgn_sel),
`endif
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {div_by_zero, quotient, remainder}
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    int sa, sb;
    logic [W-1:0] q, r;
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, q, r};
  endfunction

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    dividend = a;
    divisor  = b;
    sgn_sel  = s;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Entered #1 after an edge, k0 edges past the accepting one, with b0 busy samples already seen.
  task automatic finish_check(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                              input int k0, input int b0);
    logic [2*W:0] exp;
    int k, bc;
    exp = ref_div(a, b, s);
    k   = k0;
    bc  = b0;
    while (!done && k < 40) begin
      bc += int'(busy);
      @(posedge clk);
      #1;
      k++;
    end
    check("latency", k, (b == '0) ? 0 : W);
    check("busy_cycles", bc, (b == '0) ? 0 : W);
    check("done", done, 1);
    check("quotient", quotient, exp[2*W-1:W]);
    check("remainder", remainder, exp[W-1:0]);
    check("div_by_zero", div_by_zero, exp[2*W]);
  endtask

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [2*W:0] exp;
    exp = ref_div(a, b, s);
    launch(a, b, s);
    finish_check(a, b, s, 0, 0);
    @(posedge clk);
    #1;
    check("done_pulse", done, 0);
    check("hold_quotient", quotient, exp[2*W-1:W]);
    check("hold_remainder", remainder, exp[W-1:0]);
  endtask

  initial begin
    int ndone;
    logic [W-1:0] ra, rb;
    logic rs;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    sgn_sel  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_div(8'd100, 8'd7, 1'b0);
    do_div(8'd5, 8'd0, 1'b0);

    // start pulsed mid-run must not disturb the operation in flight
    launch(8'd200, 8'd10, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    dividend = 8'd9;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_check(8'd200, 8'd10, 1'b0, 3, 3);
    @(posedge clk);
    #1;

    // reset three cycles into a run aborts it without a done pulse
    launch(8'd255, 8'd1, 1'b0);
    repeat (2) @(posedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    ndone = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      ndone += int'(done);
    end
    check("abort_no_done", ndone, 0);
    do_div(8'd255, 8'd1, 1'b0);

    // back-to-back: start held during DONE is accepted there and clears results
    launch(8'd100, 8'd7, 1'b0);
    finish_check(8'd100, 8'd7, 1'b0, 0, 0);
    launch(8'd50, 8'd3, 1'b0);
    check("b2b_done_drop", done, 0);
    check("b2b_busy", busy, 1);
    check("b2b_quotient_clr", quotient, 0);
    check("b2b_remainder_clr", remainder, 0);
    finish_check(8'd50, 8'd3, 1'b0, 0, 0);
    launch(8'd9, 8'd0, 1'b0);
    finish_check(8'd9, 8'd0, 1'b0, 0, 0);
    @(posedge clk);
    #1;
    check("b2b_done_pulse", done, 0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    do_div(8'hF9, 8'd2, 1'b1);
    do_div(8'h80, 8'hFF, 1'b1);
    do_div(8'd7, 8'hFE, 1'b1);
    do_div(8'hF9, 8'd0, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
`ifdef SEQ_DIVIDER_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      do_div(ra, rb, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
